// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic unit: opcodes, FSM state
// encoding and saturation-limit helpers.
// Ports: none (package).
package seq_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MULT = 2'b10,
    DONE = 2'b11
  } state_t;

  // Largest signed value representable in 'width' bits.
  function automatic int sat_max(input int unsigned width);
    longint lim;
    lim = longint'(1) << (width - 1);
    return int'(lim - longint'(1));
  endfunction

  // Smallest signed value representable in 'width' bits.
  function automatic int sat_min(input int unsigned width);
    longint lim;
    lim = longint'(1) << (width - 1);
    return int'(-lim);
  endfunction

endpackage

// File: rtl/seq_arith_if.sv
// Operation bus between a controller (master) and the arithmetic unit (slave).
// Signals: start/sel/A/B issue an operation; busy/done/Q/overflow report it.
interface seq_arith_if #(
  parameter int unsigned WIDTH = 8
);
  logic                    start;
  logic [1:0]              sel;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] Q;
  logic                    overflow;

  modport master (output start, sel, A, B, input busy, done, Q, overflow);
  modport slave  (input start, sel, A, B, output busy, done, Q, overflow);
endinterface

// File: rtl/seq_arith_mult_core.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports: clk, rst (async, active-high); load latches a_mag/b_mag and clears
// the product; ready_c is high once all WIDTH steps are done; product is the
// 2*WIDTH-bit unsigned result.
module seq_mult_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic                 ready_c,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  // Shift-add datapath: multiplicand moves left, multiplier bits consumed LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (load) begin
      mcand   <= PW'(a_mag);
      mplier  <= b_mag;
      product <= '0;
      cnt     <= CW'(WIDTH);
    end else if (cnt != '0) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign ready_c = (cnt == '0);

endmodule

// File: rtl/seq_arith_unit.sv
// Registered signed arithmetic unit: ADD, SUB, MUL (iterative) and ACC on
// WIDTH-bit two's-complement operands with a start/busy/done handshake.
// Ports: clk; rst (async, active-high); bus (seq_arith_if.slave: start, sel,
// A, B in; busy, done, Q, overflow out).
// Build option: define SEQ_ARITH_SAT_EN to clamp Q on overflow instead of
// wrapping modulo 2^WIDTH.
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  seq_arith_if.slave bus
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;
  // Product magnitude limits for a positive / negative signed result.
  localparam logic [PW-1:0] POS_LIM = PW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [PW-1:0] NEG_LIM = PW'(64'd1 << (WIDTH - 1));
`ifdef SEQ_ARITH_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  state_t           state, next;
  logic             capture_c, finish_c;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_in, b_in, a_mag_c, b_mag_c;
  logic             mult_ready_c;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] wrap_c, res_c;
  logic             ovf_c, neg_c;
  logic [WIDTH-1:0] q_r;
  logic             ovf_r, busy_r, done_r;

  // Operand magnitudes for the multiplier; the most negative value maps to 2^(WIDTH-1).
  assign a_in    = bus.A;
  assign b_in    = bus.B;
  assign a_mag_c = a_in[MSB] ? (~a_in + WIDTH'(1)) : a_in;
  assign b_mag_c = b_in[MSB] ? (~b_in + WIDTH'(1)) : b_in;

  seq_mult_core #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (capture_c && (bus.sel == OP_MUL)),
    .a_mag   (a_mag_c),
    .b_mag   (b_mag_c),
    .ready_c (mult_ready_c),
    .product (product)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next state. MULT holds one extra cycle after the last step so the
  // product settles in the core before the result is registered.
  always_comb begin
    next      = state;
    capture_c = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        capture_c = 1'b1;
        next      = (bus.sel == OP_MUL) ? MULT : EXEC;
      end
      EXEC: begin
        finish_c = 1'b1;
        next     = DONE;
      end
      MULT: if (mult_ready_c) begin
        finish_c = 1'b1;
        next     = DONE;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Result and overflow from the captured operands.
  always_comb begin
    wrap_c = '0;
    ovf_c  = 1'b0;
    res_c  = '0;
    neg_c  = a_q[MSB] ^ b_q[MSB];
    case (op_q)
      OP_ADD: begin
        wrap_c = a_q + b_q;
        ovf_c  = (a_q[MSB] == b_q[MSB]) && (wrap_c[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        wrap_c = a_q - b_q;
        ovf_c  = (a_q[MSB] != b_q[MSB]) && (wrap_c[MSB] != a_q[MSB]);
      end
      OP_ACC: begin
        wrap_c = acc + a_q;
        ovf_c  = (acc[MSB] == a_q[MSB]) && (wrap_c[MSB] != acc[MSB]);
      end
      default: begin  // OP_MUL
        wrap_c = neg_c ? (~product[WIDTH-1:0] + WIDTH'(1)) : product[WIDTH-1:0];
        ovf_c  = neg_c ? (product > NEG_LIM) : (product > POS_LIM);
      end
    endcase
    res_c = wrap_c;
`ifdef SEQ_ARITH_SAT_EN
    // Clamp toward the sign of the true (unwrapped) result.
    if (ovf_c) begin
      if (op_q == OP_MUL)      res_c = neg_c    ? SAT_MIN : SAT_MAX;
      else if (op_q == OP_ACC) res_c = acc[MSB] ? SAT_MIN : SAT_MAX;
      else                     res_c = a_q[MSB] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  // Operand capture, result registers, accumulator and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      acc    <= '0;
      q_r    <= '0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (capture_c) begin
        a_q  <= a_in;
        b_q  <= b_in;
        op_q <= bus.sel;
      end
      if (finish_c) begin
        q_r   <= res_c;
        ovf_r <= ovf_c;
        if (op_q == OP_ACC) acc <= res_c;
      end
      busy_r <= (next == EXEC) || (next == MULT);
      done_r <= (next == DONE);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.Q        = q_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit at WIDTH=4: directed scenarios,
// exhaustive operand sweep and randomized traffic against a reference model
// built from plain integer arithmetic.
module tb_seq_arith_unit;
  import seq_arith_pkg::*;

  localparam int W    = 4;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   acc_m       = 0;

  seq_arith_if #(.WIDTH(W)) bus ();

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int t);
    int m;
    m = t & (2 ** W - 1);
    if (m >= 2 ** (W - 1)) m -= 2 ** W;
    return m;
  endfunction

  // Reference: exact integer result, range test, then wrap or clamp.
  function automatic void ref_op(input logic [1:0] op, input int a, input int b,
                                 output int q, output int ovf);
    int t;
    case (op)
      OP_ADD:  t = a + b;
      OP_SUB:  t = a - b;
      OP_MUL:  t = a * b;
      default: t = acc_m + a;
    endcase
    ovf = (t > MAXV || t < MINV) ? 1 : 0;
    q   = wrap(t);
`ifdef SEQ_ARITH_SAT_EN
    if (ovf != 0) q = (t > MAXV) ? MAXV : MINV;
`endif
    if (op == OP_ACC) acc_m = q;
  endfunction

  // Called on a falling edge; returns one falling edge later with start dropped.
  task automatic issue(input logic [1:0] op, input int a, input int b);
    bus.start = 1'b1;
    bus.sel   = op;
    bus.A     = W'(a);
    bus.B     = W'(b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic op_check(input logic [1:0] op, input int a, input int b,
                          input string tag, output int q_obs);
    int q_e, o_e, lat;
    ref_op(op, a, b, q_e, o_e);
    issue(op, a, b);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q_obs = int'(bus.Q);
    check({tag, " latency"}, lat, (op == OP_MUL) ? W + 2 : 2);
    check($sformatf("%s q op=%0d a=%0d b=%0d", tag, op, a, b), q_obs, q_e);
    check($sformatf("%s ovf op=%0d a=%0d b=%0d", tag, op, a, b), int'(bus.overflow), o_e);
    @(negedge clk);
    check({tag, " done pulse width"}, int'(bus.done), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    acc_m = 0;
  endtask

  initial begin
    int q, q_e, o_e, dones, qs, os;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sel   = OP_ADD;
    bus.A     = '0;
    bus.B     = '0;
    #1;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset q", int'(bus.Q), 0);
    check("reset ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Add / subtract boundaries.
    op_check(OP_ADD, 7, 1, "add7+1", q);
`ifdef SEQ_ARITH_SAT_EN
    check("add7+1 literal", q, 7);
`else
    check("add7+1 literal", q, -8);
`endif
    op_check(OP_ADD, 3, -5, "add3-5", q);
    op_check(OP_SUB, -8, 1, "sub-8-1", q);
    op_check(OP_SUB, -8, -8, "sub-8+8", q);
    check("sub-8+8 literal", q, 0);

    // Multiply: in range, wrap, most negative operand.
    op_check(OP_MUL, -2, 3, "mul-2*3", q);
    check("mul-2*3 literal", q, -6);
    op_check(OP_MUL, -3, 5, "mul-3*5", q);
    op_check(OP_MUL, -8, -1, "mul-8*-1", q);

    // Accumulate from reset.
    do_reset();
    op_check(OP_ACC, 3, 0, "acc1", q);
    op_check(OP_ACC, 3, 0, "acc2", q);
    op_check(OP_ACC, 3, 0, "acc3", q);
`ifdef SEQ_ARITH_SAT_EN
    check("acc3 literal", q, 7);
`else
    check("acc3 literal", q, -7);
`endif

    // start and operand changes while a multiply is in flight.
    ref_op(OP_MUL, -3, 5, q_e, o_e);
    issue(OP_MUL, -3, 5);
    bus.start = 1'b1;
    bus.sel   = OP_ADD;
    bus.A     = W'(7);
    bus.B     = W'(7);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'(-1);
    dones = 0; qs = 0; os = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        qs = int'(bus.Q);
        os = int'(bus.overflow);
      end
    end
    check("busy-start done count", dones, 1);
    check("busy-start q", qs, q_e);
    check("busy-start ovf", os, o_e);

    // Reset in the middle of a multiply.
    issue(OP_MUL, 5, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", int'(bus.busy), 0);
    check("midrst q", int'(bus.Q), 0);
    check("midrst ovf", int'(bus.overflow), 0);
    check("midrst done", int'(bus.done), 0);
    acc_m = 0;
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("midrst no done", dones, 0);
    op_check(OP_ACC, 1, 0, "post-rst acc", q);
    check("post-rst acc literal", q, 1);

    // Exhaustive sweep over all opcodes and operands.
    for (int op = 0; op < 4; op++)
      for (int a = MINV; a <= MAXV; a++)
        for (int b = MINV; b <= MAXV; b++)
          op_check(2'(op), a, b, "sweep", q);

    // Randomized traffic with random idle gaps.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] rop;
      int ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = int'($urandom_range(0, 2 ** W - 1)) + MINV;
      rb  = int'($urandom_range(0, 2 ** W - 1)) + MINV;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op_check(rop, ra, rb, "rand", q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
